// File: rtl/debug_dump_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_sequencer_pkg
// Description : Shared constants for the debug dump sequencer: debug-writer
//               group IDs, the length of the ID walk and the FSM state
//               encoding. The optional latch groups are enabled by defining
//               the macro DEBUG_DUMP_LATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_dump_sequencer_pkg;

    localparam logic [5:0] REG_BASE    = 6'h00;
    localparam logic [5:0] PC_ID       = 6'h22;
    localparam logic [5:0] LATCH_BASE  = 6'h24;
    localparam logic [5:0] SELECT_NONE = 6'h3F;

    localparam int NUM_REGS  = 32;
    localparam int NUM_LATCH = 8;

`ifdef DEBUG_DUMP_LATCH_EN
    localparam int NUM_IDS = NUM_REGS + 1 + NUM_LATCH;
`else
    localparam int NUM_IDS = NUM_REGS + 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_COLLECT    = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Maps a position in the dump walk to the group ID sent to the writers:
    // registers first, then the PC, then (optionally) the latch groups.
    function automatic logic [5:0] id_of(input logic [5:0] index);
        logic [5:0] id;
        if (index < 6'(NUM_REGS)) begin
            id = REG_BASE + index;
        end else if (index == 6'(NUM_REGS)) begin
            id = PC_ID;
        end else begin
`ifdef DEBUG_DUMP_LATCH_EN
            id = LATCH_BASE + (index - 6'(NUM_REGS + 1));
`else
            id = PC_ID;
`endif
        end
        return id;
    endfunction

endpackage : debug_dump_sequencer_pkg
`default_nettype wire

// File: rtl/debug_dump_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_sequencer_if
// Description : Bundles the control, debug-writer and frame-output signals of
//               the debug dump sequencer.
//               slave  : the sequencer (consumes i_*, drives o_*)
//               master : the surrounding system / debug writers / consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_dump_sequencer_if #(
    parameter int NB_FRAME  = 32,
    parameter int NB_SELECT = 6
);
    logic                 i_start;
    logic [NB_FRAME-1:0]  i_frame_from_mips;
    logic                 i_frame_valid;
    logic                 i_eod;
    logic [NB_SELECT-1:0] o_request_select;
    logic [NB_FRAME-1:0]  o_frame;
    logic                 o_frame_valid;
    logic                 i_frame_ready;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    modport slave (
        input  i_start, i_frame_from_mips, i_frame_valid, i_eod, i_frame_ready,
        output o_request_select, o_frame, o_frame_valid, o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_frame_from_mips, i_frame_valid, i_eod, i_frame_ready,
        input  o_request_select, o_frame, o_frame_valid, o_busy, o_done, o_error
    );
endinterface : debug_dump_sequencer_if
`default_nettype wire

// File: rtl/debug_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_fifo
// Description : First-word fall-through frame buffer. dout shows the head
//               word whenever the buffer is non-empty and reads as zero when
//               empty. DEPTH must be a power of two so the pointers wrap
//               naturally.
// Ports       : clk, rst (async, active high), push/din, pop/dout,
//               full, empty, count (occupancy, 0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int NB_PTR = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [NB_PTR-1:0] r_wr_ptr;
    logic [NB_PTR-1:0] r_rd_ptr;
    logic [NB_PTR:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + NB_PTR'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + NB_PTR'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (NB_PTR+1)'(1);
                2'b01:   r_count <= r_count - (NB_PTR+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == (NB_PTR+1)'(DEPTH));
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule : debug_frame_fifo
`default_nettype wire

// File: rtl/debug_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_sequencer
// Description : Walks the debug writers through every group ID, gathers up to
//               MAX_WORDS frames per group into a frame buffer and streams
//               them out. A group only opens when the buffer can absorb a
//               full group, so the buffer can never overflow.
//               Optional latch groups: define DEBUG_DUMP_LATCH_EN.
// Ports       : i_clock, i_reset (async, active high)
//               bus (slave modport): i_start, i_frame_from_mips,
//               i_frame_valid, i_eod, i_frame_ready, o_request_select,
//               o_frame, o_frame_valid, o_busy, o_done, o_error
// Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_sequencer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int NB_FRAME   = 32,
    parameter int NB_SELECT  = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WORDS  = 3,
    parameter int NB_TIMEOUT = 4
) (
    input  wire logic             i_clock,
    input  wire logic             i_reset,
    debug_dump_sequencer_if.slave bus
);
    localparam int NB_PTR  = $clog2(FIFO_DEPTH);
    localparam int NB_WCNT = $clog2(MAX_WORDS + 1);

    // The counter is compared one below all-ones so that the group closes on
    // the same edge the counter reaches all-ones: 2**NB_TIMEOUT-1 cycles max.
    localparam logic [NB_TIMEOUT-1:0] c_timeout_last = {NB_TIMEOUT{1'b1}} - NB_TIMEOUT'(1);

    state_t                r_state,    w_state_next;
    logic [5:0]            r_index,    w_index_next;
    logic [NB_WCNT-1:0]    r_word_cnt, w_word_cnt_next;
    logic [NB_TIMEOUT-1:0] r_timeout,  w_timeout_next;
    logic                  r_error,    w_error_next;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [NB_PTR:0]       w_count;
    logic [NB_PTR:0]       w_free;
    logic                  w_timeout_hit;

    debug_frame_fifo #(
        .WIDTH (NB_FRAME),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clock),
        .rst   (i_reset),
        .push  (w_push),
        .din   (bus.i_frame_from_mips),
        .pop   (w_pop),
        .dout  (bus.o_frame),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_pop         = !w_empty && bus.i_frame_ready;
    assign w_free        = (NB_PTR+1)'(FIFO_DEPTH) - w_count;
    assign w_timeout_hit = (r_timeout == c_timeout_last);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_word_cnt <= '0;
            r_timeout  <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_index    <= w_index_next;
            r_word_cnt <= w_word_cnt_next;
            r_timeout  <= w_timeout_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_word_cnt_next = r_word_cnt;
        w_timeout_next  = r_timeout;
        w_error_next    = r_error;
        w_push          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = ST_WAIT_SPACE;
                    w_index_next = '0;
                    w_error_next = 1'b0;
                end
            end
            ST_WAIT_SPACE: begin
                if (w_free >= (NB_PTR+1)'(MAX_WORDS)) begin
                    w_state_next    = ST_COLLECT;
                    w_word_cnt_next = '0;
                    w_timeout_next  = '0;
                end
            end
            ST_COLLECT: begin
                w_timeout_next = r_timeout + NB_TIMEOUT'(1);
                if (bus.i_frame_valid) begin
                    if (r_word_cnt < NB_WCNT'(MAX_WORDS)) begin
                        w_push          = !w_full;
                        w_word_cnt_next = r_word_cnt + NB_WCNT'(1);
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
                if (bus.i_eod || w_timeout_hit) begin
                    if (!bus.i_eod) w_error_next = 1'b1;
                    if (r_index == 6'(NUM_IDS - 1)) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_index_next = r_index + 6'd1;
                        w_state_next = ST_WAIT_SPACE;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_empty) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.o_request_select = (r_state == ST_COLLECT) ? NB_SELECT'(id_of(r_index)) : '1;
    assign bus.o_frame_valid    = !w_empty;
    assign bus.o_busy           = (r_state != ST_IDLE);
    assign bus.o_done           = (r_state == ST_DONE);
    assign bus.o_error          = r_error;

endmodule : debug_dump_sequencer
`default_nettype wire
